// File: rtl/tof_udp_pkg.sv
// Shared constants and types for the TOF UDP Ethernet TX word packer.
package tof_udp_pkg;

    localparam int LANES = 4;
    localparam int IN_W  = 16;
    localparam int OUT_W = 64;
    localparam int ACC_W = IN_W * (LANES - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_e;

    // Byte enables for a beat whose highest populated lane is 'lane'.
    function automatic logic [7:0] keep_for_lane(input logic [1:0] lane);
        logic [7:0] keep;
        case (lane)
            2'd0:    keep = 8'h03;
            2'd1:    keep = 8'h0F;
            2'd2:    keep = 8'h3F;
            default: keep = 8'hFF;
        endcase
        return keep;
    endfunction

endpackage

// File: rtl/tof_udp_word_packer.sv
// Packs a 16-bit HELIX-framed stream (tuser marks the length word) into
// 64-bit beats with tkeep, dropping and counting framing errors.
module tof_udp_word_packer
    import tof_udp_pkg::*;
#(
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     s_axis_aclk,
    input  logic                     s_axis_aresetn,
    input  logic [IN_W-1:0]          s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tlast,
    input  logic                     s_axis_tuser,
    output logic [OUT_W-1:0]         m_axis_tdata,
    output logic [7:0]               m_axis_tkeep,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tuser,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic                     err_pulse
);

    state_e                   state_q, state_d;
    logic [1:0]               lane_q, lane_d;
    logic [ACC_W-1:0]         acc_q, acc_d;
    logic                     acc_user_q, acc_user_d;
    logic [OUT_W-1:0]         out_data_q, out_data_d;
    logic [7:0]               out_keep_q, out_keep_d;
    logic                     out_vld_q, out_vld_d;
    logic                     out_last_q, out_last_d;
    logic                     out_user_q, out_user_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic                     err_pulse_q;

    logic                     accept;
    logic                     take;
    logic                     err;
    logic [1:0]               eff_lane;
    logic [ACC_W-1:0]         eff_acc;
    logic                     eff_user;
    logic [OUT_W-1:0]         beat;

    // Output register can take a new beat when empty or draining this cycle.
    assign s_axis_tready = !out_vld_q || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;

    // Framing policing, lane accumulation and output-register load/drain.
    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        acc_d      = acc_q;
        acc_user_d = acc_user_q;
        out_data_d = out_data_q;
        out_keep_d = out_keep_q;
        out_last_d = out_last_q;
        out_user_d = out_user_q;
        out_vld_d  = out_vld_q && !m_axis_tready;
        take       = 1'b0;
        err        = 1'b0;
        eff_lane   = lane_q;
        eff_acc    = acc_q;
        eff_user   = acc_user_q;
        beat       = '0;

        if (accept) begin
            if (s_axis_tuser) begin
                // A length word always opens a packet; a half-built beat is abandoned.
                take     = 1'b1;
                eff_lane = 2'd0;
                eff_acc  = '0;
                eff_user = 1'b1;
                err      = (state_q == IN_PKT) && (lane_q != 2'd0);
            end else if (state_q == IN_PKT) begin
                take = 1'b1;
            end else begin
                err = 1'b1;
            end
        end

        if (take) begin
            beat = {{IN_W{1'b0}}, eff_acc};
            beat[{eff_lane, 4'b0000} +: IN_W] = s_axis_tdata;
            if (eff_lane == 2'd3 || s_axis_tlast) begin
                out_data_d = beat;
                out_keep_d = keep_for_lane(eff_lane);
                out_last_d = s_axis_tlast;
                out_user_d = eff_user;
                out_vld_d  = 1'b1;
                lane_d     = 2'd0;
                acc_d      = '0;
                acc_user_d = 1'b0;
                state_d    = s_axis_tlast ? IDLE : IN_PKT;
            end else begin
                acc_d      = beat[ACC_W-1:0];
                acc_user_d = eff_user;
                lane_d     = eff_lane + 2'd1;
                state_d    = IN_PKT;
            end
        end

        err_cnt_d = (err && (err_cnt_q != {ERR_CNT_WIDTH{1'b1}})) ? err_cnt_q + 1'b1 : err_cnt_q;
    end

    // State, accumulator, output beat and error registers.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_q     <= IDLE;
            lane_q      <= 2'd0;
            acc_q       <= '0;
            acc_user_q  <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_vld_q   <= 1'b0;
            out_last_q  <= 1'b0;
            out_user_q  <= 1'b0;
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            acc_q       <= acc_d;
            acc_user_q  <= acc_user_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_vld_q   <= out_vld_d;
            out_last_q  <= out_last_d;
            out_user_q  <= out_user_d;
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= err;
        end
    end

    assign m_axis_tdata  = out_data_q;
    assign m_axis_tkeep  = out_keep_q;
    assign m_axis_tvalid = out_vld_q;
    assign m_axis_tlast  = out_last_q;
    assign m_axis_tuser  = out_user_q;
    assign err_count     = err_cnt_q;
    assign err_pulse     = err_pulse_q;

endmodule
